// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and sizing helpers for the
// digit-serial adder/subtractor (serial_adder).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide beats needed to cover a WIDTH-bit operand.
  function automatic int nbeats(input int width, input int digit);
    return width / digit;
  endfunction

  // Beat counter width; never narrower than one bit so a single-beat
  // configuration still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells.
// c_msb_in exposes the carry into the top cell so overflow can be
// cross-checked against the carry out.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    logic c;
    s        = '0;
    c_msb_in = 1'b0;
    c        = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder/subtractor processed DIGIT bits per clock,
// least-significant digit first, with valid/ready on both sides.
// Optional macro SERIAL_ADDER_SAT_EN: saturate sum on signed overflow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBEATS = nbeats(WIDTH, DIGIT);
  localparam int CNT_W  = cnt_width(NBEATS);

  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [WIDTH-1:0]        r_a, r_b, r_acc;
  logic                    r_carry, r_a_msb, r_b_msb;
  logic [WIDTH-1:0]        r_sum;
  logic                    r_cout, r_ovf;

  logic [DIGIT-1:0]        w_s;
  logic                    w_co, w_c_msb_in;
  logic                    w_accept, w_last, w_ovf;
  logic [WIDTH-1:0]        w_b_in, w_acc_next, w_result;
  logic [WIDTH+DIGIT-1:0]  w_cat;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x        (r_a[DIGIT-1:0]),
    .y        (r_b[DIGIT-1:0]),
    .ci       (r_carry),
    .s        (w_s),
    .co       (w_co),
    .c_msb_in (w_c_msb_in)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt == CNT_W'(NBEATS - 1));
  assign w_b_in     = sub ? ~b : b;
  // New digit enters at the top; after NBEATS beats the LSD sits at bit 0.
  assign w_cat      = {w_s, r_acc};
  assign w_acc_next = w_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_ovf      = (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);

`ifdef SERIAL_ADDER_SAT_EN
  logic [WIDTH-1:0] w_sat;
  assign w_sat    = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_result = w_ovf ? w_sat : w_acc_next;
`else
  assign w_result = w_acc_next;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Control-side datapath state: counter, carry, operand MSBs and results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_carry <= sub ? 1'b1 : cin;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= w_b_in[WIDTH-1];
      end
    end else if (r_state == RUN) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_carry <= w_co;
      if (w_last) begin
        assert (w_ovf == (w_co ^ w_c_msb_in));
        r_sum  <= w_result;
        r_cout <= w_co;
        r_ovf  <= w_ovf;
      end
    end
  end

  // Operand and partial-sum shift registers; contents are don't-care
  // outside RUN so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_accept) begin
      r_a <= a;
      r_b <= w_b_in;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_acc <= w_acc_next;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 with DIGIT=2
// (main instance) and DIGIT=8 (single-beat instance).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin, sub, out_ready;
  logic       sel;

  logic       in_ready0, out_valid0, cout0, ovf0;
  logic [7:0] sum0;
  logic       in_ready1, out_valid1, cout1, ovf1;
  logic [7:0] sum1;

  logic       o_in_ready, o_out_valid, o_cout, o_ovf;
  logic [7:0] o_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  assign o_in_ready  = sel ? in_ready1  : in_ready0;
  assign o_out_valid = sel ? out_valid1 : out_valid0;
  assign o_sum       = sel ? sum1       : sum0;
  assign o_cout      = sel ? cout1      : cout0;
  assign o_ovf       = sel ? ovf1       : ovf0;

  // Present operands for one edge (accept happens on that edge).
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from accept until out_valid, or -1 if it never rises.
  task automatic wait_done(output int n);
    n = 0;
    while (!o_out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_out_valid) n = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", o_in_ready); end
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", o_out_valid); end
    total++; if (o_sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {o_cout, o_ovf}); end
  endtask

  task automatic test_add_ovf();
    int n;
    start_op(8'h3C, 8'h55, 1'b0, 1'b0);
    total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL run_in_ready got=%b want=0", o_in_ready); end
    wait_done(n);
    total++; if (n !== 4) begin bad++; $display("FAIL add_latency got=%0d want=4", n); end
    total++; if (o_sum !== 8'h91) begin bad++; $display("FAIL add_sum got=%h want=91", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b01) begin bad++; $display("FAIL add_flags got=%b want=01", {o_cout, o_ovf}); end
    release_out();
    total++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin bad++; $display("FAIL add_release got=%b%b want=01", o_out_valid, o_in_ready); end
  endtask

  task automatic test_carry_wrap();
    int n;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      start_op(8'hFF, 8'h01, 1'b1, 1'b0);
      wait_done(n);
      total++; if (n !== (k == 1 ? 1 : 4)) begin bad++; $display("FAIL wrap_latency_d%0d got=%0d want=%0d", k, n, (k == 1 ? 1 : 4)); end
      total++; if (o_sum !== 8'h01) begin bad++; $display("FAIL wrap_sum_d%0d got=%h want=01", k, o_sum); end
      total++; if ({o_cout, o_ovf} !== 2'b10) begin bad++; $display("FAIL wrap_flags_d%0d got=%b want=10", k, {o_cout, o_ovf}); end
      release_out();
    end
    sel = 1'b0;
  endtask

  task automatic test_sub();
    int n;
    start_op(8'h10, 8'h20, 1'b1, 1'b1);
    wait_done(n);
    total++; if (o_sum !== 8'hF0) begin bad++; $display("FAIL sub_sum got=%h want=F0", o_sum); end
    total++; if ({o_cout, o_ovf} !== 2'b00) begin bad++; $display("FAIL sub_flags got=%b want=00", {o_cout, o_ovf}); end
    release_out();
    // 0x80 - 0x01: negative minus positive wraps to positive.
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(n);
`ifdef SERIAL_ADDER_SAT_EN
    total++; if (o_sum !== 8'h80) begin bad++; $display("FAIL subovf_sum got=%h want=80", o_sum); end
`else
    total++; if (o_sum !== 8'h7F) begin bad++; $display("FAIL subovf_sum got=%h want=7F", o_sum); end
`endif
    total++; if ({o_cout, o_ovf} !== 2'b11) begin bad++; $display("FAIL subovf_flags got=%b want=11", {o_cout, o_ovf}); end
    release_out();
  endtask

  task automatic test_backpressure();
    int n;
    start_op(8'h3C, 8'h55, 1'b0, 1'b0);
    wait_done(n);
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_sum !== 8'h91 || {o_cout, o_ovf} !== 2'b01) begin
        bad++;
        $display("FAIL hold_%0d got=v%b r%b s%h f%b want=v1 r0 s91 f01", i, o_out_valid, o_in_ready, o_sum, {o_cout, o_ovf});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=v%b r%b want=v0 r1", o_out_valid, o_in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL hold_second_accept got=%b want=0", o_in_ready); end
    wait_done(n);
    total++; if (n !== 4 || o_sum !== 8'h03) begin bad++; $display("FAIL hold_second_result got=lat%0d s%h want=lat4 s03", n, o_sum); end
    release_out();
  endtask

  task automatic test_mid_reset();
    int n;
    start_op(8'h3C, 8'h55, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_hs got=r%b v%b want=r1 v0", o_in_ready, o_out_valid); end
    total++; if (o_sum !== 8'h00 || {o_cout, o_ovf} !== 2'b00) begin bad++; $display("FAIL midrst_out got=s%h f%b want=s00 f00", o_sum, {o_cout, o_ovf}); end
    repeat (4) @(posedge clk); #1;
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale got=%b want=0", o_out_valid); end
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    wait_done(n);
    total++; if (n !== 4 || o_sum !== 8'h03) begin bad++; $display("FAIL midrst_fresh got=lat%0d s%h want=lat4 s03", n, o_sum); end
    release_out();
  endtask

  task automatic test_signed_ovf();
    int n;
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(n);
`ifdef SERIAL_ADDER_SAT_EN
    total++; if (o_sum !== 8'h7F) begin bad++; $display("FAIL sovf_sum got=%h want=7F", o_sum); end
`else
    total++; if (o_sum !== 8'h80) begin bad++; $display("FAIL sovf_sum got=%h want=80", o_sum); end
`endif
    total++; if ({o_cout, o_ovf} !== 2'b01) begin bad++; $display("FAIL sovf_flags got=%b want=01", {o_cout, o_ovf}); end
    release_out();
    // out_ready with nothing pending must leave the block idle.
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin bad++; $display("FAIL idle_out_ready got=v%b r%b want=v0 r1", o_out_valid, o_in_ready); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_add_ovf();
    test_carry_wrap();
    test_sub();
    test_backpressure();
    test_mid_reset();
    test_signed_ovf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
